mem_rd_arbiter: RTL and testbench

Shares the single memory read port between instruction fetch (IF) and the load path (DM). Each requester uses the same enable/address/ready/data handshake the fetch unit already drives. The memory port sees one transaction at a time. The block sits between `fetch`/load-store logic and the memory model, and sequences grant, forward, capture and return.

---
 rtl/mem_rd_arbiter_pkg.sv | 21 ++
 rtl/mem_rd_arbiter_pick.sv | 20 ++
 rtl/mem_rd_arbiter.sv | 84 ++++++++
 tb/tb_mem_rd_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_arbiter_pkg.sv
// mem_rd_arbiter_pkg: shared widths, FSM and grant encodings for the memory read arbiter
package mem_rd_arbiter_pkg;

    localparam int ADDR_SIZE  = 15;
    localparam int INSTR_SIZE = 15;

    typedef logic [ADDR_SIZE:0]  addr_t;
    typedef logic [INSTR_SIZE:0] instr_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_GNT_IF = 1'b0,
        ARB_GNT_DM = 1'b1
    } arb_gnt_t;

endpackage

// File: rtl/mem_rd_arbiter_pick.sv
// rd_arb_pick: chooses the winning requester; ARB_RR_EN selects round-robin ties, else DM wins ties
module rd_arb_pick
    import mem_rd_arbiter_pkg::*;
(
    input  logic     if_req,
    input  logic     dm_req,
    input  arb_gnt_t last_grant,
    output arb_gnt_t pick
);

`ifdef ARB_RR_EN
    assign pick = (if_req && dm_req) ? ((last_grant == ARB_GNT_IF) ? ARB_GNT_DM : ARB_GNT_IF)
                                     : (dm_req ? ARB_GNT_DM : ARB_GNT_IF);
`else
    logic unused_pick;
    assign unused_pick = if_req ^ last_grant;
    assign pick = dm_req ? ARB_GNT_DM : ARB_GNT_IF;
`endif

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one memory read port between fetch and load paths (ARB_RR_EN enables round-robin ties)
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_rd_enable,
    input  logic [ADDR_SIZE:0]    if_rd_addr,
    output logic                  if_rd_ready,
    output logic [INSTR_SIZE:0]   if_rd_data,
    input  logic                  dm_rd_enable,
    input  logic [ADDR_SIZE:0]    dm_rd_addr,
    output logic                  dm_rd_ready,
    output logic [INSTR_SIZE:0]   dm_rd_data,
    output logic                  mem_rd_enable,
    output logic [ADDR_SIZE:0]    mem_rd_addr,
    input  logic                  mem_rd_ready,
    input  logic [INSTR_SIZE:0]   mem_rd_data
);

    arb_state_t state;
    arb_gnt_t   grant;
    arb_gnt_t   last_grant;
    arb_gnt_t   pick;
    addr_t      addr_q;
    instr_t     data_q;
    logic       ret_if;
    logic       ret_dm;

    rd_arb_pick u_pick (
        .if_req     (if_rd_enable),
        .dm_req     (dm_rd_enable),
        .last_grant (last_grant),
        .pick       (pick)
    );

    // grant, forward to memory, capture the word, then return it for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ARB_IDLE;
            grant         <= ARB_GNT_IF;
            last_grant    <= ARB_GNT_DM;
            addr_q        <= '0;
            data_q        <= '0;
            mem_rd_enable <= 1'b0;
            ret_if        <= 1'b0;
            ret_dm        <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (if_rd_enable || dm_rd_enable) begin
                        grant         <= pick;
                        addr_q        <= (pick == ARB_GNT_DM) ? dm_rd_addr : if_rd_addr;
                        mem_rd_enable <= 1'b1;
                        state         <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_rd_ready) begin
                        data_q        <= mem_rd_data;
                        last_grant    <= grant;
                        mem_rd_enable <= 1'b0;
                        ret_if        <= (grant == ARB_GNT_IF);
                        ret_dm        <= (grant == ARB_GNT_DM);
                        state         <= ARB_DONE;
                    end
                end
                default: begin
                    ret_if <= 1'b0;
                    ret_dm <= 1'b0;
                    state  <= ARB_IDLE;
                end
            endcase
        end
    end

    // a requester that dropped its enable before the return cycle gets no pulse
    assign if_rd_ready = ret_if & if_rd_enable;
    assign dm_rd_ready = ret_dm & dm_rd_enable;
    assign if_rd_data  = data_q;
    assign dm_rd_data  = data_q;
    assign mem_rd_addr = addr_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: randomized and directed checks of mem_rd_arbiter against a transaction-level model
module tb_mem_rd_arbiter;
    import mem_rd_arbiter_pkg::*;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   reset;
    logic   if_rd_enable, dm_rd_enable, if_rd_ready, dm_rd_ready;
    addr_t  if_rd_addr, dm_rd_addr, mem_rd_addr;
    instr_t if_rd_data, dm_rd_data, mem_rd_data;
    logic   mem_rd_enable, mem_rd_ready;

    always #5 clk = ~clk;

    mem_rd_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .if_rd_enable  (if_rd_enable),
        .if_rd_addr    (if_rd_addr),
        .if_rd_ready   (if_rd_ready),
        .if_rd_data    (if_rd_data),
        .dm_rd_enable  (dm_rd_enable),
        .dm_rd_addr    (dm_rd_addr),
        .dm_rd_ready   (dm_rd_ready),
        .dm_rd_data    (dm_rd_data),
        .mem_rd_enable (mem_rd_enable),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_ready  (mem_rd_ready),
        .mem_rd_data   (mem_rd_data)
    );

    int n_chk = 0;
    int n_pass = 0;

    // model: one outstanding transaction, seen as (requester, address, returned?)
    bit     m_act, m_ret, m_who, m_last;
    addr_t  m_addr;
    instr_t m_data;
    int     m_cnt, m_lat;
    bit     e_if, e_dm;
    bit     rand_data, spur, kick;
    int     lat_fixed;
    bit     obs_who[$];
    instr_t obs_dat[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_act = 0; m_ret = 0; m_last = 1; m_who = 0;
        m_addr = '0; m_data = '0; e_if = 0; e_dm = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_en"}, 32'(mem_rd_enable), 0);
        check({tag, "_mem_addr"}, 32'(mem_rd_addr), 0);
        check({tag, "_if_rdy"}, 32'(if_rd_ready), 0);
        check({tag, "_dm_rdy"}, 32'(dm_rd_ready), 0);
        check({tag, "_if_data"}, 32'(if_rd_data), 0);
        check({tag, "_dm_data"}, 32'(dm_rd_data), 0);
    endtask

    task automatic do_reset();
        reset = 1; if_rd_enable = 0; dm_rd_enable = 0; mem_rd_ready = 0;
        @(posedge clk); #1;
        check_zero("rst");
        @(negedge clk) reset = 0;
        model_reset();
        @(posedge clk); #1;
    endtask

    // one clock cycle: memory responder, output checks, model advance
    task automatic step();
        mem_rd_ready = 0;
        mem_rd_data  = instr_t'($urandom);
        if (m_act && !m_ret) begin
            m_cnt++;
            if (m_cnt >= m_lat) begin
                mem_rd_ready = 1;
                mem_rd_data  = rand_data ? instr_t'($urandom) : instr_t'(m_addr + 16'h8000);
            end
        end else if (kick || (spur && $urandom_range(0, 3) == 0)) mem_rd_ready = 1;
        e_if = m_act && m_ret && !m_who && if_rd_enable;
        e_dm = m_act && m_ret && m_who && dm_rd_enable;
        @(negedge clk);
        check("mem_en", 32'(mem_rd_enable), 32'(m_act && !m_ret));
        check("mem_addr", 32'(mem_rd_addr), 32'(m_addr));
        check("if_rdy", 32'(if_rd_ready), 32'(e_if));
        check("dm_rdy", 32'(dm_rd_ready), 32'(e_dm));
        check("if_data", 32'(if_rd_data), 32'(m_data));
        check("dm_data", 32'(dm_rd_data), 32'(m_data));
        if (if_rd_ready) begin obs_who.push_back(0); obs_dat.push_back(if_rd_data); end
        if (dm_rd_ready) begin obs_who.push_back(1); obs_dat.push_back(dm_rd_data); end
        @(posedge clk);
        if (m_ret) begin
            m_act = 0; m_ret = 0;
        end else if (m_act) begin
            if (mem_rd_ready) begin m_data = mem_rd_data; m_ret = 1; m_last = m_who; end
        end else if (if_rd_enable || dm_rd_enable) begin
            m_who = (if_rd_enable && dm_rd_enable) ? (RR ? !m_last : 1'b1) : dm_rd_enable;
            m_addr = m_who ? dm_rd_addr : if_rd_addr;
            m_act = 1; m_cnt = 0;
            m_lat = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
        end
        #1;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        do begin
            step();
            if (e_if) if_rd_enable = 0;
            if (e_dm) dm_rd_enable = 0;
            n++;
        end while ((m_act || if_rd_enable || dm_rd_enable) && n < max);
        check("drain", 32'(m_act || if_rd_enable || dm_rd_enable), 0);
    endtask

    task automatic drive_reqs();
        if (if_rd_enable) begin
            if (e_if || $urandom_range(0, 39) == 0) if_rd_enable = 0;
        end else if ($urandom_range(0, 2) == 0) begin
            if_rd_enable = 1; if_rd_addr = addr_t'($urandom);
        end
        if (dm_rd_enable) begin
            if (e_dm || $urandom_range(0, 39) == 0) dm_rd_enable = 0;
        end else if ($urandom_range(0, 2) == 0) begin
            dm_rd_enable = 1; dm_rd_addr = addr_t'($urandom);
        end
    endtask

    initial begin
        if_rd_addr = '0; dm_rd_addr = '0; mem_rd_data = '0;
        rand_data = 0; spur = 0; kick = 0; lat_fixed = 1;
        model_reset();
        do_reset();

        // single fetch, memory answers on the second busy cycle
        obs_who.delete(); obs_dat.delete();
        lat_fixed = 2; if_rd_addr = 'h10; if_rd_enable = 1;
        run_idle(20);
        check("single_cnt", 32'(obs_who.size()), 1);
        if (obs_who.size() >= 1) begin
            check("single_who", 32'(obs_who[0]), 0);
            check("single_data", 32'(obs_dat[0]), 'h8010);
        end

        // simultaneous requests from reset
        do_reset();
        obs_who.delete(); obs_dat.delete();
        lat_fixed = 1; if_rd_addr = 'h20; dm_rd_addr = 'h40; if_rd_enable = 1; dm_rd_enable = 1;
        run_idle(20);
        check("tie_cnt", 32'(obs_who.size()), 2);
        if (obs_who.size() >= 2) begin
            check("tie_first", 32'(obs_who[0]), RR ? 0 : 1);
            check("tie_first_data", 32'(obs_dat[0]), RR ? 'h8020 : 'h8040);
            check("tie_second", 32'(obs_who[1]), RR ? 1 : 0);
            check("tie_second_data", 32'(obs_dat[1]), RR ? 'h8040 : 'h8020);
        end

        // both requesters keep coming back: grants must alternate
        do_reset();
        obs_who.delete(); obs_dat.delete();
        if_rd_enable = 1; dm_rd_enable = 1;
        for (int n = 0; n < 60 && obs_who.size() < 3; n++) begin
            step();
            if_rd_enable = !e_if;
            dm_rd_enable = !e_dm;
        end
        if_rd_enable = 0; dm_rd_enable = 0;
        run_idle(20);
        check("alt_cnt", 32'(obs_who.size()), 3);
        if (obs_who.size() >= 3) begin
            check("alt_0", 32'(obs_who[0]), RR ? 0 : 1);
            check("alt_1", 32'(obs_who[1]), RR ? 1 : 0);
            check("alt_2", 32'(obs_who[2]), RR ? 0 : 1);
        end

        // fetch abandons its request while the memory read is in flight
        obs_who.delete(); obs_dat.delete();
        lat_fixed = 3; if_rd_addr = 'h30; if_rd_enable = 1;
        step(); step();
        if_rd_enable = 0;
        run_idle(20);
        check("abandon_cnt", 32'(obs_who.size()), 0);
        check("abandon_data", 32'(if_rd_data), 'h8030);

        // reset in the middle of a busy transaction, late memory ready ignored
        lat_fixed = 4; if_rd_addr = 'h50; if_rd_enable = 1;
        step(); step();
        #2 reset = 1;
        #1 check_zero("async");
        mem_rd_ready = 1;
        @(posedge clk); #1;
        mem_rd_ready = 0; if_rd_enable = 0;
        do_reset();
        obs_who.delete(); obs_dat.delete();
        kick = 1; step(); kick = 0;
        step();
        lat_fixed = 1; if_rd_addr = 'h60; if_rd_enable = 1;
        run_idle(20);
        check("post_rst_cnt", 32'(obs_who.size()), 1);
        if (obs_who.size() >= 1) check("post_rst_data", 32'(obs_dat[0]), 'h8060);

        // randomized traffic with stray memory readies and random data
        rand_data = 1; spur = 1; lat_fixed = 0;
        for (int n = 0; n < 800; n++) begin
            drive_reqs();
            step();
        end
        if_rd_enable = 0; dm_rd_enable = 0; spur = 0;
        run_idle(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
